// File: rtl/axi_rd_pkg.sv
// Shared types and helpers for the AXI read-data router and its arbiter.
package axi_rd_pkg;

    localparam int NUM_S_DEF  = 7;
    localparam int NUM_M_DEF  = 2;
    localparam int ID_W_DEF   = 4;
    localparam int MSEL_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    typedef logic [ID_W_DEF+MSEL_W_DEF-1:0] rid_s_t;
    typedef logic [ID_W_DEF-1:0]            rid_m_t;
    typedef logic [DATA_W_DEF-1:0]          data_t;
    typedef logic [1:0]                     resp_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // Ceiling log2 with a floor of 1 so a 2-entry index still gets one bit.
    function automatic int clog2_fn(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N = 7,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_oh,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] idx_s;
    logic         found_s;

    // Scan from ptr upward and keep the first hit.
    always_comb begin
        gnt_oh  = {N{1'b0}};
        gnt_idx = {W{1'b0}};
        found_s = 1'b0;
        idx_s   = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx_s = W'((int'(ptr) + i) % N);
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                gnt_idx        = idx_s;
                gnt_oh[idx_s]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/axi_rd_router.sv
// AXI R-channel crossbar: NUM_S slaves to NUM_M masters, round-robin with burst lock.
// Optional output skid slices per master when RD_ROUTER_OUT_REG_EN is defined.
module axi_rd_router
    import axi_rd_pkg::*;
#(
    parameter int NUM_S  = 7,
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int MSEL_W = 4,
    parameter int DATA_W = 32,
    localparam int IDS_W = ID_W + MSEL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_S*IDS_W-1:0]  s_rid,
    input  logic [NUM_S*DATA_W-1:0] s_rdata,
    input  logic [NUM_S*2-1:0]      s_rresp,
    input  logic [NUM_S-1:0]        s_rlast,
    input  logic [NUM_S-1:0]        s_rvalid,
    output logic [NUM_S-1:0]        s_rready,
    output logic [NUM_M*ID_W-1:0]   m_rid,
    output logic [NUM_M*DATA_W-1:0] m_rdata,
    output logic [NUM_M*2-1:0]      m_rresp,
    output logic [NUM_M-1:0]        m_rlast,
    output logic [NUM_M-1:0]        m_rvalid,
    input  logic [NUM_M-1:0]        m_rready,
    output logic                    id_err
);

    localparam int SEL_W = clog2_fn(NUM_S);
    localparam int MI_W  = clog2_fn(NUM_M);
    localparam int PL_W  = ID_W + DATA_W + 3;

    rd_state_e          state_r;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic [SEL_W-1:0]   gnt_q_r;
    logic [SEL_W-1:0]   arb_idx_s;
    logic [SEL_W-1:0]   g_s;
    logic [NUM_S-1:0]   arb_oh_s;
    logic [NUM_S-1:0]   s_rready_s;
    logic [NUM_M-1:0]   route_s;
    logic               active_s;
    logic               g_valid_s;
    logic               g_last_s;
    logic               legal_s;
    logic               hs_s;
    logic               tgt_ready_s;
    logic [IDS_W-1:0]   g_rid_s;
    logic [MSEL_W-1:0]  msel_s;
    logic [MI_W-1:0]    msel_idx_s;
    logic [DATA_W-1:0]  g_data_s;
    logic [1:0]         g_resp_s;

    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        if (int'(p) == NUM_S - 1) begin
            return {SEL_W{1'b0}};
        end else begin
            return p + SEL_W'(1);
        end
    endfunction

    rr_arbiter #(.N(NUM_S), .W(SEL_W)) u_arb (
        .req     (s_rvalid),
        .ptr     (rr_ptr_r),
        .gnt_oh  (arb_oh_s),
        .gnt_idx (arb_idx_s)
    );

    // Pick the routed slave: the locked one in BURST, the arbiter winner in IDLE.
    always_comb begin
        if (state_r == BURST) begin
            g_s      = gnt_q_r;
            active_s = ~rst;
        end else begin
            g_s      = arb_idx_s;
            active_s = (|arb_oh_s) & ~rst;
        end
    end

    assign g_rid_s    = s_rid[int'(g_s)*IDS_W +: IDS_W];
    assign g_data_s   = s_rdata[int'(g_s)*DATA_W +: DATA_W];
    assign g_resp_s   = s_rresp[int'(g_s)*2 +: 2];
    assign g_last_s   = s_rlast[g_s];
    assign g_valid_s  = active_s & s_rvalid[g_s];
    assign msel_s     = g_rid_s[IDS_W-1:ID_W];
    assign legal_s    = (int'(msel_s) < NUM_M);
    assign msel_idx_s = MI_W'(msel_s);
    assign hs_s       = g_valid_s & s_rready_s[g_s];
    assign s_rready   = s_rready_s;
    assign id_err     = g_valid_s & ~legal_s;

    // Steer the granted beat: ready back to its slave, valid to its target master.
    always_comb begin
        s_rready_s = {NUM_S{1'b0}};
        route_s    = {NUM_M{1'b0}};
        if (g_valid_s) begin
            s_rready_s[g_s] = tgt_ready_s;
            if (legal_s) begin
                route_s[msel_idx_s] = 1'b1;
            end else begin
                route_s = {NUM_M{1'b0}};
            end
        end else begin
            s_rready_s = {NUM_S{1'b0}};
        end
    end

    // Arbitration state: lock on a non-final grant, release and rotate on the RLAST handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= {SEL_W{1'b0}};
            gnt_q_r  <= {SEL_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (active_s) begin
                        if (hs_s && g_last_s) begin
                            rr_ptr_r <= ptr_inc(g_s);
                        end else begin
                            gnt_q_r <= g_s;
                            state_r <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (hs_s && g_last_s) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= ptr_inc(gnt_q_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef RD_ROUTER_OUT_REG_EN
    logic [NUM_M-1:0] full_s;

    assign tgt_ready_s = legal_s ? ~full_s[msel_idx_s] : 1'b1;

    for (genvar m = 0; m < NUM_M; m++) begin : g_skid
        logic [PL_W-1:0] mem_r [2];
        logic [1:0]      cnt_r;
        logic            rd_r;
        logic            wr_r;
        logic            push_s;
        logic            pop_s;

        assign full_s[m] = (cnt_r == 2'd2);
        assign push_s    = route_s[m] & ~full_s[m];
        assign pop_s     = (cnt_r != 2'd0) & m_rready[m];

        // Two-entry FIFO keeps one beat per cycle while ready is taken from not-full.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r <= 2'd0;
                rd_r  <= 1'b0;
                wr_r  <= 1'b0;
            end else begin
                if (push_s) begin
                    mem_r[wr_r] <= {g_rid_s[ID_W-1:0], g_data_s, g_resp_s, g_last_s};
                    wr_r        <= ~wr_r;
                end
                if (pop_s) begin
                    rd_r <= ~rd_r;
                end
                cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
            end
        end

        assign m_rvalid[m] = (cnt_r != 2'd0);
        assign {m_rid[m*ID_W +: ID_W], m_rdata[m*DATA_W +: DATA_W], m_rresp[m*2 +: 2], m_rlast[m]} =
            (cnt_r != 2'd0) ? mem_r[rd_r] : {PL_W{1'b0}};
    end
`else
    assign tgt_ready_s = legal_s ? m_rready[msel_idx_s] : 1'b1;
    assign m_rvalid    = route_s;

    // Every master sees the granted payload; zeros when nothing is granted.
    always_comb begin
        if (active_s) begin
            m_rid   = {NUM_M{g_rid_s[ID_W-1:0]}};
            m_rdata = {NUM_M{g_data_s}};
            m_rresp = {NUM_M{g_resp_s}};
            m_rlast = {NUM_M{g_last_s}};
        end else begin
            m_rid   = {(NUM_M*ID_W){1'b0}};
            m_rdata = {(NUM_M*DATA_W){1'b0}};
            m_rresp = {(NUM_M*2){1'b0}};
            m_rlast = {NUM_M{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_router.sv
// Scoreboard bench for axi_rd_router (default build, combinational forward path).
module tb_axi_rd_router;

    localparam int NS  = 7;
    localparam int NM  = 2;
    localparam int IW  = 4;
    localparam int DW  = 32;
    localparam int IDS = 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*IDS-1:0] s_rid;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS*2-1:0]   s_rresp;
    logic [NS-1:0]     s_rlast;
    logic [NS-1:0]     s_rvalid;
    logic [NS-1:0]     s_rready;
    logic [NM*IW-1:0]  m_rid;
    logic [NM*DW-1:0]  m_rdata;
    logic [NM*2-1:0]   m_rresp;
    logic [NM-1:0]     m_rlast;
    logic [NM-1:0]     m_rvalid;
    logic [NM-1:0]     m_rready;
    logic              id_err;

    beat_t q0[$];
    beat_t q1[$];
    beat_t got_b;
    beat_t exp_b;
    int    pass_cnt   = 0;
    int    total_cnt  = 0;
    int    err_pulses = 0;
    int    fcnt [NS];
    int    order [3] = '{1, 4, 6};

    axi_rd_router dut (
        .clk      (clk),
        .rst      (rst),
        .s_rid    (s_rid),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rlast  (s_rlast),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .m_rid    (m_rid),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rlast  (m_rlast),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .id_err   (id_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l);
        return {id, d, d[1:0], l};
    endfunction

    task automatic drive(input int s, input logic [7:0] rid, input logic [31:0] data, input logic last);
        s_rid[s*IDS +: IDS] = rid;
        s_rdata[s*DW +: DW] = data;
        s_rresp[s*2 +: 2]   = data[1:0];
        s_rlast[s]          = last;
        s_rvalid[s]         = 1'b1;
    endtask

    task automatic push(input int m, input beat_t b);
        if (m == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        s_rvalid = '0;
        s_rid    = '0;
        s_rdata  = '0;
        s_rresp  = '0;
        s_rlast  = '0;
        m_rready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pop and compare on every master-side handshake; count id_err pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (id_err) err_pulses++;
            for (int m = 0; m < NM; m++) begin
                if (m_rvalid[m] && m_rready[m]) begin
                    got_b = {m_rid[m*IW +: IW], m_rdata[m*DW +: DW], m_rresp[m*2 +: 2], m_rlast[m]};
                    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                        chk($sformatf("m%0d_unexpected_beat", m), 64'(got_b), 64'd0);
                    end else begin
                        if (m == 0) exp_b = q0.pop_front();
                        else        exp_b = q1.pop_front();
                        chk($sformatf("m%0d_beat", m), 64'(got_b), 64'(exp_b));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        int last_pushed;
        int exp_s;

        // Reset: outputs held at zero even with a valid slave present.
        rst      = 1'b1;
        s_rvalid = '0;
        s_rid    = '0;
        s_rdata  = '0;
        s_rresp  = '0;
        s_rlast  = '0;
        m_rready = 2'b11;
        drive(2, 8'h15, 32'hDEAD_0001, 1'b1);
        @(negedge clk);
        chk("rst_s_rready", 64'(s_rready), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata), 64'd0);
        chk("rst_id_err", 64'(id_err), 64'd0);
        do_reset();

        // Single beat slave 2 -> master 1, then rr_ptr has moved to 3.
        drive(2, 8'h15, 32'hA5A5_0001, 1'b1);
        push(1, mk(4'h5, 32'hA5A5_0001, 1'b1));
        @(negedge clk);
        chk("single_m_rvalid", 64'(m_rvalid), 64'b10);
        chk("single_m_rid1", 64'(m_rid[7:4]), 64'h5);
        chk("single_m_rid0_copy", 64'(m_rid[3:0]), 64'h5);
        chk("single_s_rready", 64'(s_rready), 64'b0000100);
        next_cycle();
        s_rvalid[2] = 1'b0;
        drive(0, 8'h01, 32'h0000_00B0, 1'b1);
        drive(4, 8'h02, 32'h0000_00C0, 1'b1);
        push(0, mk(4'h2, 32'h0000_00C0, 1'b1));
        push(0, mk(4'h1, 32'h0000_00B0, 1'b1));
        @(negedge clk);
        chk("rr_ptr_after_2", 64'(s_rready), 64'b0010000);
        next_cycle();
        s_rvalid[4] = 1'b0;
        @(negedge clk);
        chk("rr_wrap_to_0", 64'(s_rready), 64'b0000001);
        next_cycle();
        s_rvalid[0] = 1'b0;
        @(negedge clk);
        chk("idle_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("idle_payload_zero", 64'(m_rdata), 64'd0);

        // Burst lock: slave 0 4-beat burst to M0, slave 3 waits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h03, 32'h10 + 32'(i), (i == 3));
            push(0, mk(4'h3, 32'h10 + 32'(i), (i == 3)));
            if (i == 1) begin
                drive(3, 8'h17, 32'h0000_0030, 1'b1);
                push(1, mk(4'h7, 32'h0000_0030, 1'b1));
            end
            @(negedge clk);
            chk("lock_s0_ready", 64'(s_rready[0]), 64'd1);
            if (i >= 1) chk("lock_s3_blocked", 64'(s_rready[3]), 64'd0);
            next_cycle();
        end
        s_rvalid[0] = 1'b0;
        @(negedge clk);
        chk("lock_s3_next", 64'(s_rready), 64'b0001000);
        next_cycle();
        s_rvalid[3] = 1'b0;

        // Fairness: slaves 1, 4, 6 always requesting.
        do_reset();
        for (int s = 0; s < NS; s++) fcnt[s] = 0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) begin
                drive(order[j], {4'h0, 4'(order[j])}, 32'(order[j] * 256 + fcnt[order[j]]), 1'b1);
            end
            exp_s = order[i % 3];
            push(0, mk(4'(exp_s), 32'(exp_s * 256 + fcnt[exp_s]), 1'b1));
            @(negedge clk);
            chk($sformatf("fair_grant_%0d", i), 64'(s_rready), 64'd1 << exp_s);
            for (int s = 0; s < NS; s++) begin
                if (s_rready[s]) fcnt[s]++;
            end
            next_cycle();
        end
        s_rvalid = '0;

        // Backpressure: m_rready[0] low for 3 cycles mid-burst.
        do_reset();
        k = 0;
        c = 0;
        last_pushed = -1;
        drive(2, 8'h12, 32'h0000_0050, 1'b1);
        push(1, mk(4'h2, 32'h0000_0050, 1'b1));
        while (k < 4 && c < 20) begin
            m_rready[0] = !(c >= 1 && c <= 3);
            drive(0, 8'h09, 32'h40 + 32'(k), (k == 3));
            if (k != last_pushed) begin
                push(0, mk(4'h9, 32'h40 + 32'(k), (k == 3)));
                last_pushed = k;
            end
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                chk("bp_ready_low", 64'(s_rready[0]), 64'd0);
                chk("bp_payload_held", 64'(m_rdata[31:0]), 64'h41);
                chk("bp_lock_held", 64'(s_rready[2]), 64'd0);
            end
            if (s_rvalid[0] && s_rready[0]) k++;
            c++;
            next_cycle();
        end
        if (k < 4) chk("bp_timeout", 64'(k), 64'd4);
        s_rvalid[0] = 1'b0;
        m_rready    = 2'b11;
        @(negedge clk);
        chk("bp_next_grant", 64'(s_rready), 64'b0000100);
        next_cycle();
        s_rvalid[2] = 1'b0;

        // Illegal master field: drained with id_err, even with masters not ready.
        do_reset();
        m_rready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            drive(5, 8'h31, 32'h70 + 32'(i), (i == 1));
            @(negedge clk);
            chk("ill_s_rready", 64'(s_rready), 64'b0100000);
            chk("ill_m_rvalid", 64'(m_rvalid), 64'd0);
            chk("ill_id_err", 64'(id_err), 64'd1);
            next_cycle();
        end
        s_rvalid[5] = 1'b0;
        m_rready    = 2'b11;
        @(negedge clk);
        chk("ill_id_err_clear", 64'(id_err), 64'd0);

        // Reset in the middle of a burst from slave 3.
        do_reset();
        drive(3, 8'h14, 32'h0000_0080, 1'b0);
        push(1, mk(4'h4, 32'h0000_0080, 1'b0));
        @(negedge clk);
        chk("rmb_beat1", 64'(s_rready), 64'b0001000);
        next_cycle();
        drive(3, 8'h14, 32'h0000_0081, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rmb_s_rready_zero", 64'(s_rready), 64'd0);
        chk("rmb_m_rvalid_zero", 64'(m_rvalid), 64'd0);
        chk("rmb_m_rdata_zero", 64'(m_rdata), 64'd0);
        chk("rmb_m_rid_zero", 64'(m_rid), 64'd0);
        next_cycle();
        rst = 1'b0;
        drive(0, 8'h06, 32'h0000_0090, 1'b1);
        push(0, mk(4'h6, 32'h0000_0090, 1'b1));
        @(negedge clk);
        chk("rmb_restart_from_0", 64'(s_rready), 64'b0000001);
        next_cycle();
        s_rvalid = '0;
        repeat (2) next_cycle();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("id_err_pulses", 64'(err_pulses), 64'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
